fifo_rd_axis: RTL
=================

Name: fifo_rd_axis

Overview:
Read-side drain engine for the dual-clock BRAM FIFO.
- Lives in the FIFO read clock domain.
- Issues pops against the FIFO's pop/empty interface and absorbs the fixed BRAM read latency with an in-flight tag pipeline.
- Presents the data as an AXI4-Stream master with programmable-length packets (tlast).
- Sizes pops by credit, so a stalled consumer never loses a word.

Parameters:
- DW, 16: data width; must match the FIFO's FIFO_DW.
- RD_LAT, 2: cycles from pop to valid fifo_dt_i. Legal values are 1 (non-registered RAM) or 2 (registered RAM).
- OB_AW, 2: log2 of output-buffer depth. OBUF_DEPTH = 2**OB_AW, which must be >= RD_LAT+2 for full throughput (checked by elaboration assertion).
- LW, 16: width of the packet-length input and the beat counter.

Ports:
- clk_i  in  1  read-domain clock
- rst_ni  in  1  reset; asynchronous assert, active-low
- fifo_empty_i  in  1  FIFO empty. Contract: it already reflects every pop issued up to the previous cycle.
- fifo_pop_o  out  1  pop strobe to the FIFO
- fifo_dt_i  in  DW  FIFO read data, valid RD_LAT cycles after the pop
- flush_i  in  1  synchronous drop of all buffered and in-flight data
- pkt_len_i  in  LW  beats per packet; 0 means tlast is never asserted
- m_axis_tvalid_o  out  1  AXIS valid
- m_axis_tready_i  in  1  AXIS ready
- m_axis_tdata_o  out  DW  AXIS data
- m_axis_tlast_o  out  1  high on the last beat of a packet
- level_o  out  OB_AW+1  output-buffer occupancy
- busy_o  out  1  high while any word is in flight or buffered

Behaviour:
- Reset (async, rst_ni=0):
  - fifo_pop_o, m_axis_tvalid_o, m_axis_tlast_o, busy_o all 0.
  - level_o = 0, m_axis_tdata_o = 0.
  - Tag pipe, buffer pointers and beat counter cleared.
- Credit and pop decision:
  - inflight = number of set bits in the RD_LAT-deep tag shift register.
  - fifo_pop_o = !fifo_empty_i & !flush_i & (level + inflight < OBUF_DEPTH). This is combinational from registered state and fifo_empty_i.
  - The credit check is conservative: a same-cycle AXIS handshake does not free a credit that cycle.
- Tag pipe:
  - Bit 0 loads fifo_pop_o each cycle; the pipe shifts each cycle.
  - When the bit at stage RD_LAT-1 is set, fifo_dt_i is written into the output buffer at the end of that cycle.
- Latency: pop in cycle t → fifo_dt_i sampled in cycle t+RD_LAT → m_axis_tvalid_o high from cycle t+RD_LAT+1.
- Throughput: 1 beat/clk sustained while the FIFO is non-empty and tready=1.
- Output buffer:
  - Synchronous FIFO of depth OBUF_DEPTH; data is registered out.
  - m_axis_tvalid_o = (level != 0); m_axis_tdata_o = head entry.
  - Write and read in the same cycle leave level unchanged.
  - An overflow write is impossible by the credit rule; an assertion flags it.
- AXIS rules:
  - Once tvalid is high, tdata and tlast are held stable until tready.
  - tvalid never drops without a handshake, except on flush or reset.
- Packet counter:
  - cnt counts accepted beats. tlast = (pkt_len_eff != 0) & (cnt == pkt_len_eff-1).
  - pkt_len_eff is pkt_len_i while cnt==0. It is latched into len_r on the first beat of a packet and len_r is used thereafter, so mid-packet changes to pkt_len_i are ignored.
  - On the tlast handshake, cnt returns to 0.
  - pkt_len_i=1 gives tlast on every beat.
  - cnt wraps modulo 2**LW when pkt_len_eff=0.
- Flush (flush_i=1 at an edge):
  - Clears the tag pipe, buffer pointers (level=0) and cnt; no pop is issued that cycle.
  - Returning in-flight data is discarded.
  - tvalid=0 in the next cycle. Flush has priority over a simultaneous handshake or write.
- busy_o = (level != 0) | (inflight != 0).
- Reset mid-packet: everything returns to reset values; the next beat starts a new packet.

Decomposition:
- Package fifo_rd_pkg holds:
  - the localparam function that computes OBUF_DEPTH;
  - the legal-RD_LAT check;
  - the typedef for tag-pipe width.
- One sub-module: fifo_rd_obuf, a single-clock synchronous FIFO (DW x 2**OB_AW) with write, read, flush, level and an async active-low reset.

Test Plan:
1. Preload the source FIFO with 8 words 0x0001..0x0008; RD_LAT=2, tready=1, pkt_len=0 → pops in cycles 0..7, tvalid from cycle 3, data 1..8 on consecutive clocks, tlast never asserted.
2. Same preload, tready held 0 → exactly 4 pops and level_o=4. Then release tready → words 1..8 arrive in order, none lost or duplicated.
3. pkt_len=3, 7 words streamed → tlast on beats 3 and 6. Change pkt_len to 2 during beat 5 → beat 6 still carries tlast. Beat 7 starts a new packet with len 2.
4. Random tready (50%) over 1000 words → scoreboard matches; OBUF overflow assertion never fires; 1 beat/clk whenever tready=1 and source non-empty.
5. flush_i pulsed with 2 words in flight and 3 buffered → next cycle tvalid=0, level=0, busy_o=0 once the pipe empties; the next words come from fresh pops only.
6. Assert rst_ni low asynchronously mid-packet (cnt=2, level=3) → all outputs 0 immediately; after release the first beat restarts cnt at 0.

Source files
------------

// File: rtl/fifo_rd_pkg.sv
// Shared definitions for the FIFO read-side drain engine.
package fifo_rd_pkg;

    // Deepest BRAM read latency the tag pipe supports.
    localparam int unsigned MAX_RD_LAT = 2;

    // One bit per read-latency stage; unused upper stages stay zero.
    typedef logic [MAX_RD_LAT-1:0] tag_pipe_t;

    // Output-buffer depth derived from its address width.
    function automatic int unsigned obuf_depth(input int unsigned ob_aw);
        return 32'd1 << ob_aw;
    endfunction

    // Only a plain (1) or output-registered (2) RAM is supported.
    function automatic bit rd_lat_legal(input int unsigned rd_lat);
        return (rd_lat == 32'd1) || (rd_lat == 32'd2);
    endfunction

endpackage

// File: rtl/fifo_rd_obuf.sv
// Small single-clock output buffer: write/read/flush with occupancy count.
module fifo_rd_obuf
    import fifo_rd_pkg::*;
#(
    parameter int unsigned DW    = 16,
    parameter int unsigned OB_AW = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr,
    input  logic [DW-1:0] wdata,
    input  logic          rd,
    input  logic          flush,
    output logic [DW-1:0] rdata,
    output logic [OB_AW:0] level
);

    localparam int unsigned DEPTH = obuf_depth(OB_AW);

    logic [DW-1:0]    mem [DEPTH];
    logic [OB_AW-1:0] wptr;
    logic [OB_AW-1:0] rptr;
    logic             rd_en;

    assign rd_en = rd && (level != '0);
    assign rdata = mem[rptr];

    // Storage, pointers and occupancy; flush wins over any write or read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else begin
            if (wr) begin
                mem[wptr] <= wdata;
                wptr      <= wptr + OB_AW'(1);
            end
            if (rd_en) begin
                rptr <= rptr + OB_AW'(1);
            end
            case ({wr, rd_en})
                2'b10:   level <= level + (OB_AW+1)'(1);
                2'b01:   level <= level - (OB_AW+1)'(1);
                default: level <= level;
            endcase
        end
    end

    // The credit rule upstream must never let a write hit a full buffer.
    always @(posedge clk) begin
        if (rst_n && !flush) begin
            assert (!(wr && (level == (OB_AW+1)'(DEPTH))))
                else $error("fifo_rd_obuf: write into full buffer");
        end
    end

endmodule

// File: rtl/fifo_rd_axis.sv
// Read-domain drain engine: credit-sized FIFO pops, read-latency tag pipe,
// output buffer and an AXI4-Stream master with programmable packet length.
module fifo_rd_axis
    import fifo_rd_pkg::*;
#(
    parameter int unsigned DW     = 16,
    parameter int unsigned RD_LAT = 2,
    parameter int unsigned OB_AW  = 2,
    parameter int unsigned LW     = 16
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          fifo_empty_i,
    output logic          fifo_pop_o,
    input  logic [DW-1:0] fifo_dt_i,
    input  logic          flush_i,
    input  logic [LW-1:0] pkt_len_i,
    output logic          m_axis_tvalid_o,
    input  logic          m_axis_tready_i,
    output logic [DW-1:0] m_axis_tdata_o,
    output logic          m_axis_tlast_o,
    output logic [OB_AW:0] level_o,
    output logic          busy_o
);

    localparam int unsigned OBUF_DEPTH = obuf_depth(OB_AW);
    localparam tag_pipe_t   TAG_MASK   = tag_pipe_t'((32'd1 << RD_LAT) - 32'd1);

    if (!rd_lat_legal(RD_LAT)) begin : g_bad_rd_lat
        $error("fifo_rd_axis: RD_LAT must be 1 or 2");
    end
    if (OBUF_DEPTH < RD_LAT + 2) begin : g_bad_depth
        $error("fifo_rd_axis: output buffer too shallow for full throughput");
    end

    logic           active;
    tag_pipe_t      tag;
    logic [OB_AW+1:0] inflight;
    logic [OB_AW:0] level;
    logic           credit_ok;
    logic           tvalid;
    logic           hs;
    logic [LW-1:0]  cnt;
    logic [LW-1:0]  len_r;
    logic [LW-1:0]  len_eff;

    // Pops stay off until the first clock after reset release.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) active <= 1'b0;
        else         active <= 1'b1;
    end

    // Count outstanding reads in the tag pipe.
    always_comb begin
        inflight = '0;
        for (int unsigned i = 0; i < MAX_RD_LAT; i++) begin
            inflight = inflight + (OB_AW+2)'(tag[i]);
        end
    end

    // Conservative credit: a same-cycle read does not free a slot.
    assign credit_ok  = ({1'b0, level} + inflight) < (OB_AW+2)'(OBUF_DEPTH);
    assign fifo_pop_o = active && !fifo_empty_i && !flush_i && credit_ok;

    // Tag pipe tracks each pop until its data returns from the RAM.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)      tag <= '0;
        else if (flush_i) tag <= '0;
        else              tag <= {tag[MAX_RD_LAT-2:0], fifo_pop_o} & TAG_MASK;
    end

    fifo_rd_obuf #(
        .DW    (DW),
        .OB_AW (OB_AW)
    ) u_obuf (
        .clk   (clk_i),
        .rst_n (rst_ni),
        .wr    (tag[RD_LAT-1]),
        .wdata (fifo_dt_i),
        .rd    (m_axis_tready_i),
        .flush (flush_i),
        .rdata (m_axis_tdata_o),
        .level (level)
    );

    assign tvalid  = (level != '0);
    assign hs      = tvalid && m_axis_tready_i && !flush_i;
    // Length comes live from the input only on the first beat, then from len_r.
    assign len_eff = (cnt == '0) ? pkt_len_i : len_r;

    assign m_axis_tvalid_o = tvalid;
    assign m_axis_tlast_o  = tvalid && (len_eff != '0) && (cnt == len_eff - LW'(1));
    assign level_o         = level;
    assign busy_o          = tvalid || (inflight != '0);

    // Beat counter and per-packet length latch.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt   <= '0;
            len_r <= '0;
        end else if (flush_i) begin
            cnt <= '0;
        end else if (hs) begin
            if (cnt == '0) len_r <= pkt_len_i;
            cnt <= m_axis_tlast_o ? '0 : cnt + LW'(1);
        end
    end

endmodule
